// File: rtl/dt_frame_sched_if.sv
// Result-stream port of the distance-transform frame scheduler.
// It carries a valid/ready byte stream and a last-byte marker.
interface dt_frame_sched_if #(
    parameter int DATA_W = 8
) ();
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/dt_frame_sched.sv
// Frame sequencer for the distance-transform engine and arbiter for its result RAM.
// Optional watchdog and ERR state are enabled by defining DT_WDOG_EN.
module dt_frame_sched #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int WDOG_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              error,
    output logic [15:0]       frame_cnt,
    output logic              dt_rst_n,
    input  logic              dt_done,
    input  logic              dt_res_wr,
    input  logic              dt_res_rd,
    input  logic [ADDR_W-1:0] dt_res_addr,
    input  logic [DATA_W-1:0] dt_res_do,
    output logic [DATA_W-1:0] dt_res_di,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_do,
    input  logic [DATA_W-1:0] ram_di,
    dt_frame_sched_if.master  out_if
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_READ = 2'd2, S_ERR = 2'd3} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    state_t            r_state, w_state_nxt;
    logic              r_busy, r_dt_rst_n;
    logic [15:0]       r_frame_cnt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_all, r_inflight, r_inflight_last;
    logic              r_out_valid, r_out_last, r_skid_valid, r_skid_last;
    logic [DATA_W-1:0] r_out_data, r_skid_data;
    logic [1:0]        w_occ, w_fill;
    logic              w_pop, w_last_xfer, w_issue, w_wdog_exp;

    assign w_pop       = r_out_valid && out_if.out_ready;
    assign w_last_xfer = w_pop && r_out_last;
    // Entries held after this cycle's pop plus the byte landing from RAM; issue only if a slot is free
    assign w_occ       = {1'b0, r_out_valid} + {1'b0, r_skid_valid};
    assign w_fill      = w_occ - {1'b0, w_pop} + {1'b0, r_inflight};
    assign w_issue     = (r_state == S_READ) && !r_rd_all && (w_fill < 2'd2);

`ifdef DT_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LIM = {{(WDOG_W-1){1'b1}}, 1'b0};
    logic [WDOG_W-1:0] r_wdog;
    logic              r_error;

    assign w_wdog_exp = (r_state == S_RUN) && (r_wdog == WDOG_LIM);
    assign error      = r_error;

    // Watchdog: counts RUN cycles, cleared whenever the engine is not running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdog <= {WDOG_W{1'b0}};
        end else if (r_state == S_RUN) begin
            r_wdog <= r_wdog + {{(WDOG_W-1){1'b0}}, 1'b1};
        end else begin
            r_wdog <= {WDOG_W{1'b0}};
        end
    end

    // Sticky timeout flag, cleared by the restart out of ERR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (w_state_nxt == S_ERR) begin
            r_error <= 1'b1;
        end else if (w_state_nxt == S_RUN) begin
            r_error <= 1'b0;
        end
    end
`else
    assign w_wdog_exp = 1'b0;
    assign error      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and RAM ownership mux; engine signals pass through only in RUN
    always_comb begin
        w_state_nxt = r_state;
        ram_wr      = 1'b0;
        ram_rd      = 1'b0;
        ram_addr    = r_rd_addr;
        ram_do      = {DATA_W{1'b0}};
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
                else       w_state_nxt = S_IDLE;
            end
            S_RUN: begin
                ram_wr   = dt_res_wr;
                ram_rd   = dt_res_rd;
                ram_addr = dt_res_addr;
                ram_do   = dt_res_do;
                if (dt_done)         w_state_nxt = S_READ;
                else if (w_wdog_exp) w_state_nxt = S_ERR;
                else                 w_state_nxt = S_RUN;
            end
            S_READ: begin
                ram_rd = w_issue;
                if (w_last_xfer) w_state_nxt = S_IDLE;
                else             w_state_nxt = S_READ;
            end
            S_ERR: begin
                if (start) w_state_nxt = S_RUN;
                else       w_state_nxt = S_ERR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered status outputs derived from the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dt_rst_n  <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_dt_rst_n <= (w_state_nxt == S_RUN);
            r_busy     <= (w_state_nxt == S_RUN) || (w_state_nxt == S_READ);
            if (w_last_xfer) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Readout address counter; parks on the last address until READ is left
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_addr       <= {ADDR_W{1'b0}};
            r_rd_all        <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rd_addr == ADDR_MAX);
            if (w_state_nxt != S_READ) begin
                r_rd_addr <= {ADDR_W{1'b0}};
                r_rd_all  <= 1'b0;
            end else if (w_issue) begin
                if (r_rd_addr == ADDR_MAX) r_rd_all  <= 1'b1;
                else                       r_rd_addr <= r_rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Two-entry output buffer: head drives the stream, skid catches the byte still in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= {DATA_W{1'b0}};
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_data  <= {DATA_W{1'b0}};
        end else if (!r_out_valid || w_pop) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_out_last   <= r_skid_last;
                r_skid_valid <= r_inflight;
                r_skid_data  <= ram_di;
                r_skid_last  <= r_inflight_last;
            end else if (r_inflight) begin
                r_out_valid <= 1'b1;
                r_out_data  <= ram_di;
                r_out_last  <= r_inflight_last;
            end else begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end else if (r_inflight) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= ram_di;
            r_skid_last  <= r_inflight_last;
        end
    end

    assign busy             = r_busy;
    assign dt_rst_n         = r_dt_rst_n;
    assign frame_cnt        = r_frame_cnt;
    assign dt_res_di        = ram_di;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_data  = r_out_data;
    assign out_if.out_last  = r_out_last;
endmodule

// File: tb/tb_dt_frame_sched.sv
// Directed bench for dt_frame_sched: RAM and engine models, full-frame readouts, stalls, restarts, abort.
// The watchdog scenario is compiled only when DT_WDOG_EN is defined.
module tb_dt_frame_sched;
    logic        clk = 1'b0;
    logic        reset, start, dt_done, dt_res_wr, dt_res_rd;
    logic [13:0] dt_res_addr, ram_addr;
    logic [7:0]  dt_res_do, dt_res_di, ram_do, ram_di;
    logic        ram_wr, ram_rd, busy, error, dt_rst_n;
    logic [15:0] frame_cnt;
    logic [7:0]  mem [0:16383];
    int          eng_cnt = 0;
    logic        eng_en = 1'b1;
    int          rd_total = 0;
    int          checks = 0;
    int          errors = 0;

    dt_frame_sched_if #(.DATA_W(8)) out_if ();

    dt_frame_sched #(.ADDR_W(14), .DATA_W(8), .WDOG_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .error(error),
        .frame_cnt(frame_cnt), .dt_rst_n(dt_rst_n), .dt_done(dt_done),
        .dt_res_wr(dt_res_wr), .dt_res_rd(dt_res_rd), .dt_res_addr(dt_res_addr),
        .dt_res_do(dt_res_do), .dt_res_di(dt_res_di), .ram_wr(ram_wr), .ram_rd(ram_rd),
        .ram_addr(ram_addr), .ram_do(ram_do), .ram_di(ram_di), .out_if(out_if.master)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_do;
        if (ram_rd) ram_di <= mem[ram_addr];
    end

    // Engine model: done pulses on its 100th cycle out of reset
    always @(posedge clk) begin
        if (!dt_rst_n) eng_cnt <= 0;
        else           eng_cnt <= eng_cnt + 1;
    end
    assign dt_done = eng_en && dt_rst_n && (eng_cnt == 99);

    always @(posedge clk) begin
        if (busy && !dt_rst_n && ram_rd) rd_total <= rd_total + 1;
    end

    task automatic run_to_read(input int pulse_at, output int hi, output int to);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        hi = 0; to = 1;
        for (int i = 0; i < 1000; i++) begin
            if (!dt_rst_n) begin to = 0; break; end
            hi++;
            start = (hi == pulse_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic stream_frame(input int pat, input int pulse_at, input int max_bytes,
                                output int n_xfer, output int n_bad, output int n_unst,
                                output int n_last, output int last_idx, output int last_cyc,
                                output int to);
        logic       pv, pr, pl;
        logic [7:0] pd, want;
        int         cyc;
        n_xfer = 0; n_bad = 0; n_unst = 0; n_last = 0; last_idx = -1; last_cyc = -1;
        to = 1; cyc = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'd0;
        while (cyc < 70000) begin
            @(negedge clk);
            if (pv && !pr && (!out_if.out_valid || out_if.out_data !== pd || out_if.out_last !== pl))
                n_unst++;
            out_if.out_ready = (pat == 0) ? 1'b1 : (((cyc % 4) == 0) || ((cyc % 4) == 3));
            start = (cyc == pulse_at);
            if (out_if.out_valid && out_if.out_ready) begin
                want = n_xfer[7:0];
                if (out_if.out_data !== want) n_bad++;
                if (out_if.out_last) begin n_last++; last_idx = n_xfer; end
                n_xfer++;
                last_cyc = cyc;
            end
            pv = out_if.out_valid; pr = out_if.out_ready;
            pd = out_if.out_data;  pl = out_if.out_last;
            cyc++;
            if (n_xfer >= max_bytes) begin to = 0; break; end
        end
        start = 1'b0;
        @(negedge clk);
        out_if.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; dt_res_wr = 1'b0; dt_res_rd = 1'b0;
        dt_res_addr = 14'd0; dt_res_do = 8'd0; out_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (dt_rst_n !== 1'b0) begin errors++; $display("FAIL rst_dt_rst_n: got %b want 0", dt_rst_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", error); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
        checks++; if ({out_if.out_valid, out_if.out_last, out_if.out_data} !== 10'd0) begin
            errors++; $display("FAIL rst_stream: got v=%b l=%b d=%h want 0", out_if.out_valid, out_if.out_last, out_if.out_data); end
        checks++; if ({ram_wr, ram_rd, ram_addr} !== 16'd0) begin
            errors++; $display("FAIL rst_ram: got wr=%b rd=%b a=%h want 0", ram_wr, ram_rd, ram_addr); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || dt_rst_n !== 1'b0) begin
            errors++; $display("FAIL idle_after_rst: got busy=%b dt_rst_n=%b want 0 0", busy, dt_rst_n); end
    endtask

    task automatic test_frame_basic;
        int hi, to, nx, nb, nu, nl, li, lc, rd0;
        rd0 = rd_total;
        run_to_read(10, hi, to);
        checks++; if (to !== 0 || hi !== 100) begin errors++; $display("FAIL run_window: got %0d cycles (to=%0d) want 100", hi, to); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b want 1", busy); end
        stream_frame(0, 50, 16384, nx, nb, nu, nl, li, lc, to);
        checks++; if (nx !== 16384 || to !== 0) begin errors++; $display("FAIL basic_count: got %0d bytes want 16384", nx); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL basic_data: got %0d bad bytes want 0", nb); end
        checks++; if (nl !== 1 || li !== 16383) begin errors++; $display("FAIL basic_last: got %0d lasts at %0d want 1 at 16383", nl, li); end
        checks++; if (lc !== 16384) begin errors++; $display("FAIL basic_rate: got last at cycle %0d want 16384", lc); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d want 1", frame_cnt); end
        checks++; if (busy !== 1'b0 || dt_rst_n !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got busy=%b dt_rst_n=%b want 0 0", busy, dt_rst_n); end
        checks++; if (rd_total - rd0 !== 16384) begin errors++; $display("FAIL basic_reads: got %0d want 16384", rd_total - rd0); end
    endtask

    task automatic test_stall_second_start;
        int hi, to, nx, nb, nu, nl, li, lc, rd0;
        rd0 = rd_total;
        run_to_read(-1, hi, to);
        checks++; if (to !== 0) begin errors++; $display("FAIL stall_enter_read: got timeout want READ"); end
        stream_frame(1, -1, 16384, nx, nb, nu, nl, li, lc, to);
        checks++; if (nx !== 16384 || to !== 0) begin errors++; $display("FAIL stall_count: got %0d bytes want 16384", nx); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL stall_data: got %0d bad bytes want 0", nb); end
        checks++; if (nu !== 0) begin errors++; $display("FAIL stall_stable: got %0d unstable stalls want 0", nu); end
        checks++; if (nl !== 1 || li !== 16383) begin errors++; $display("FAIL stall_last: got %0d lasts at %0d want 1 at 16383", nl, li); end
        checks++; if (rd_total - rd0 !== 16384) begin errors++; $display("FAIL stall_reads: got %0d want 16384", rd_total - rd0); end
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL stall_frame_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_engine_mux_abort;
        int to, nx, nb, nu, nl, li, lc, bad_wr, bad_idle;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        dt_res_wr = 1'b1; dt_res_addr = 14'h1234; dt_res_do = 8'h55; #1;
        checks++; if ({ram_wr, ram_rd, ram_addr, ram_do} !== {1'b1, 1'b0, 14'h1234, 8'h55}) begin
            errors++; $display("FAIL run_mux_wr: got wr=%b rd=%b a=%h d=%h want 1 0 1234 55", ram_wr, ram_rd, ram_addr, ram_do); end
        @(negedge clk);
        dt_res_wr = 1'b0; dt_res_rd = 1'b1; #1;
        checks++; if (ram_rd !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 14'h1234) begin
            errors++; $display("FAIL run_mux_rd: got rd=%b wr=%b a=%h want 1 0 1234", ram_rd, ram_wr, ram_addr); end
        @(negedge clk);
        dt_res_rd = 1'b0;
        checks++; if (dt_res_di !== 8'h55) begin errors++; $display("FAIL run_readback: got %h want 55", dt_res_di); end
        to = 1;
        for (int i = 0; i < 1000; i++) begin
            if (!dt_rst_n) begin to = 0; break; end
            @(negedge clk);
        end
        checks++; if (to !== 0) begin errors++; $display("FAIL mux_enter_read: got timeout want READ"); end
        bad_wr = 0;
        dt_res_wr = 1'b1; dt_res_addr = 14'h0100; dt_res_do = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            #1; if (ram_wr !== 1'b0) bad_wr++;
            @(negedge clk);
        end
        dt_res_wr = 1'b0;
        checks++; if (bad_wr !== 0) begin errors++; $display("FAIL read_wr_blocked: got %0d writes want 0", bad_wr); end
        stream_frame(0, -1, 500, nx, nb, nu, nl, li, lc, to);
        checks++; if (nx !== 500 || nb !== 0) begin errors++; $display("FAIL abort_prefix: got %0d bytes %0d bad want 500 0", nx, nb); end
        reset = 1'b0; #1;
        checks++; if ({busy, error, dt_rst_n, frame_cnt} !== 19'd0) begin
            errors++; $display("FAIL abort_status: got busy=%b err=%b rstn=%b cnt=%0d want 0", busy, error, dt_rst_n, frame_cnt); end
        checks++; if ({out_if.out_valid, out_if.out_last, out_if.out_data, ram_wr, ram_rd, ram_addr} !== 26'd0) begin
            errors++; $display("FAIL abort_outputs: got v=%b l=%b d=%h a=%h want 0", out_if.out_valid, out_if.out_last, out_if.out_data, ram_addr); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        out_if.out_ready = 1'b1;
        bad_idle = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_if.out_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) bad_idle++;
        end
        out_if.out_ready = 1'b0;
        checks++; if (bad_idle !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad_idle); end
    endtask

`ifdef DT_WDOG_EN
    task automatic test_watchdog;
        int cnt;
        eng_en = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (error) break;
            if (busy) cnt++;
            @(negedge clk);
        end
        checks++; if (cnt !== 63) begin errors++; $display("FAIL wdog_cycles: got %0d want 63", cnt); end
        checks++; if ({error, busy, dt_rst_n} !== 3'b100) begin
            errors++; $display("FAIL wdog_err: got err=%b busy=%b rstn=%b want 1 0 0", error, busy, dt_rst_n); end
        eng_en = 1'b1;
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if ({error, busy, dt_rst_n} !== 3'b011) begin
            errors++; $display("FAIL wdog_restart: got err=%b busy=%b rstn=%b want 0 1 1", error, busy, dt_rst_n); end
    endtask
`endif

    initial begin
        for (int a = 0; a < 16384; a++) mem[a] = a[7:0];
        test_reset();
        test_frame_basic();
        test_stall_second_start();
        test_engine_mux_abort();
`ifdef DT_WDOG_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
